// File: rtl/uart_tx_queue_if.sv
// Host/transmitter-facing signal bundle for uart_tx_queue.
// master = host plus transmitter side, slave = the queue itself.
interface uart_tx_queue_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]      wr_data;
   logic            wr_en;
   logic            ovf_clr;
   logic            tx_busy;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] count;
   logic            overflow;

   modport master (
      output wr_data, wr_en, ovf_clr, tx_busy,
      input  tx_data, tx_start, full, empty, count, overflow
   );

   modport slave (
      input  wr_data, wr_en, ovf_clr, tx_busy,
      output tx_data, tx_start, full, empty, count, overflow
   );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: one tx_start per byte, next launch only
// after the transmitter's busy window closes. Registered full/empty/count, sticky overflow.
module uart_tx_queue #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input logic            clk,
   input logic            reset_n,
   uart_tx_queue_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count_q, count_nxt;
   logic              full_q, empty_q, overflow_q;
   logic [7:0]        tx_data_q;
   logic              tx_start_q;
   state_t            state;
   logic              wr_ok, pop;

   // Writes are gated by the registered full flag only, so a pop in the same
   // cycle never rescues a write that arrives while full.
   assign wr_ok = bus.wr_en && !full_q;
   assign pop   = (state == IDLE) && !empty_q;

   always_comb begin
      count_nxt = count_q;
      unique case ({wr_ok, pop})
         2'b10:   count_nxt = count_q + 1'b1;
         2'b01:   count_nxt = count_q - 1'b1;
         default: count_nxt = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         count_q <= count_nxt;
         full_q  <= (count_nxt == (ADDR_W+1)'(DEPTH));
         empty_q <= (count_nxt == '0);
         // a drop in the same cycle as a clear keeps the flag set
         if (bus.wr_en && full_q) overflow_q <= 1'b1;
         else if (bus.ovf_clr)    overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rd_ptr     <= '0;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state)
            IDLE: if (!empty_q) begin
               tx_data_q  <= mem[rd_ptr];
               rd_ptr     <= rd_ptr + 1'b1;
               tx_start_q <= 1'b1;
               state      <= LAUNCH;
            end
            LAUNCH:    state <= WAIT_BUSY;
            WAIT_BUSY: if (bus.tx_busy)  state <= WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_start = tx_start_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: scoreboard of expected bytes against the
// launched stream, with a simple transmitter model that holds busy per frame.
module tb_uart_tx_queue;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] sb [$];

   // transmitter model: busy for busy_len cycles after each launch, or forced
   int cyc = 0;
   bit hold_busy = 1'b0;
   int busy_len = 10;
   int busy_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)          busy_cnt <= 0;
      else if (bus.tx_start) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign bus.tx_busy = hold_busy || (busy_cnt != 0);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // output monitor: ordering, pulse shape and launch latencies
   bit prev_start = 1'b0, prev_empty = 1'b1, prev_busy = 1'b0;
   int empty_fall_cyc = 0, busy_fall_cyc = 0, n_starts = 0, peak_cnt = 0;
   int lat_emp [$];
   int lat_bsy [$];
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_start = 1'b0;
         prev_empty = 1'b1;
         prev_busy  = 1'b0;
      end else begin
         if (prev_empty && !bus.empty)  empty_fall_cyc = cyc;
         if (prev_busy && !bus.tx_busy) busy_fall_cyc = cyc;
         if (int'(bus.count) > peak_cnt) peak_cnt = int'(bus.count);
         if (bus.tx_start) begin
            chk("single_pulse", {31'd0, prev_start}, 0);
            lat_emp.push_back(cyc - empty_fall_cyc);
            lat_bsy.push_back(cyc - busy_fall_cyc);
            n_starts++;
            chk("sb_has_entry", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) chk("tx_data_order", {24'd0, bus.tx_data}, {24'd0, sb.pop_front()});
         end
         prev_start = bus.tx_start;
         prev_empty = bus.empty;
         prev_busy  = bus.tx_busy;
      end
   end

   task automatic wr(input logic [7:0] b, input bit push);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      if (push) sb.push_back(b);
   endtask

   task automatic wr_end();
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // wait until scoreboard empty and the link has been quiet for a few cycles
   task automatic drain(input string tag, input int maxc);
      int n = 0;
      int quiet = 0;
      while (quiet < 4 && n < maxc) begin
         @(negedge clk);
         n++;
         if (sb.size() == 0 && !bus.tx_busy && bus.empty && !bus.tx_start) quiet++;
         else quiet = 0;
      end
      chk(tag, {31'd0, n >= maxc}, 0);
   endtask

   task automatic wait_starts(input string tag, input int target, input int maxc);
      int n = 0;
      while (n_starts < target && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, n_starts >= target}, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx_data"},  {24'd0, bus.tx_data}, 0);
      chk({tag, "_tx_start"}, {31'd0, bus.tx_start}, 0);
      chk({tag, "_full"},     {31'd0, bus.full}, 0);
      chk({tag, "_empty"},    {31'd0, bus.empty}, 1);
      chk({tag, "_count"},    {27'd0, bus.count}, 0);
      chk({tag, "_overflow"}, {31'd0, bus.overflow}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      reset_n = 1'b1;

      // "HELLO" back-to-back
      peak_cnt = 0;
      n0 = n_starts;
      wr(8'h48, 1); wr(8'h45, 1); wr(8'h4C, 1); wr(8'h4C, 1); wr(8'h4F, 1);
      wr_end();
      drain("hello_drain", 400);
      chk("hello_starts", n_starts - n0, 5);
      chk("hello_peak", peak_cnt, 4);
      chk("hello_empty", {31'd0, bus.empty}, 1);

      // overflow: park one byte in flight, then fill past DEPTH
      hold_busy = 1'b1;
      wr(8'hA5, 1);
      wr_end();
      wait_starts("ovf_park", n_starts + 1, 20);
      repeat (2) @(negedge clk);
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr(8'(i), i < DEPTH);
         if (i == DEPTH) begin
            chk("ovf_full16", {31'd0, bus.full}, 1);
            chk("ovf_count16", {27'd0, bus.count}, DEPTH);
            chk("ovf_not_yet", {31'd0, bus.overflow}, 0);
         end
      end
      wr_end();
      chk("ovf_set", {31'd0, bus.overflow}, 1);
      chk("ovf_count_hold", {27'd0, bus.count}, DEPTH);
      repeat (5) @(negedge clk);
      chk("ovf_sticky", {31'd0, bus.overflow}, 1);
      // drop and clear together: set wins
      @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.ovf_clr = 1'b1;
      @(negedge clk); bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
      chk("ovf_set_wins", {31'd0, bus.overflow}, 1);
      @(negedge clk); bus.ovf_clr = 1'b1;
      @(negedge clk); bus.ovf_clr = 1'b0;
      chk("ovf_cleared", {31'd0, bus.overflow}, 0);

      // write/pop collision while full
      @(negedge clk); hold_busy = 1'b0;
      @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
      @(negedge clk); bus.wr_en = 1'b0;
      chk("coll_count", {27'd0, bus.count}, DEPTH - 1);
      chk("coll_overflow", {31'd0, bus.overflow}, 1);
      chk("coll_full", {31'd0, bus.full}, 0);
      drain("coll_drain", 1500);

      // wrap-around at an interleaved rate
      @(negedge clk); bus.ovf_clr = 1'b1;
      @(negedge clk); bus.ovf_clr = 1'b0;
      busy_len = 2;
      n0 = n_starts;
      for (int i = 0; i < 40; i++) begin
         wr(8'(i * 7 + 3), 1);
         @(negedge clk); bus.wr_en = 1'b0;
         repeat ($urandom_range(2, 5)) @(negedge clk);
      end
      drain("wrap_drain", 1000);
      chk("wrap_starts", n_starts - n0, 40);
      chk("wrap_no_ovf", {31'd0, bus.overflow}, 0);

      // latency: empty->start and busy-fall->next start
      busy_len = 10;
      n0 = lat_emp.size();
      wr(8'h31, 1); wr(8'h32, 1);
      wr_end();
      drain("lat_drain", 200);
      chk("lat_empty_to_start", lat_emp[n0], 1);
      chk("lat_busy_to_next", lat_bsy[n0 + 1], 2);

      // reset mid-frame flushes everything
      wr(8'h61, 1); wr(8'h62, 1); wr(8'h63, 1);
      wr_end();
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_reset("midrst");
      sb.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      n0 = n_starts;
      wr(8'h5A, 1);
      wr_end();
      drain("post_rst_drain", 100);
      chk("post_rst_starts", n_starts - n0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO and transmit sequencer sitting directly upstream of the UART transmitter in `uart_top`. It accepts bytes from the host side at up to one per clock. It then drives the transmitter's `tx_data`/`tx_start` pair one byte at a time, waiting for each frame to finish before launching the next, so callers never have to poll the transmitter. It also reports occupancy and latches a sticky overflow flag when writes are dropped.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `ADDR_W`, 4: log2(DEPTH); must match `DEPTH`.

- `clk`  in  1  system clock, 50 MHz nominal.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe, sampled on rising `clk`.
- `ovf_clr`  in  1  clears `overflow`.
- `tx_busy`  in  1  transmitter busy: start bit through stop bit.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_start`  out  1  single-cycle launch pulse to the transmitter.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  bytes held, excluding the byte in flight.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each ADDR_W bits, wrapping modulo DEPTH. `count` is a separate ADDR_W+1-bit register.
- **Write:** accepted when `wr_en` is high and registered `full` is 0. The byte is stored at `wr_ptr`, then `wr_ptr` increments.
- **Dropped write:** when `wr_en` is high and `full` is 1, the write is dropped, `overflow` is set, and pointers and count are unchanged.
- **Write/pop collision:** a write attempted while `full` is 1 is dropped even if a pop happens in the same cycle.
- **Overflow flags:** `ovf_clr` clears `overflow`. If `ovf_clr` and a dropped write occur in the same cycle, set wins.
- **Count update:** with a simultaneous accepted write and pop, `count` is unchanged; otherwise +1 or -1.
- **FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `empty` is 0, pop `mem[rd_ptr]` into the `tx_data` register, increment `rd_ptr`, and go to LAUNCH. Otherwise stay.
  - LAUNCH: `tx_start` is 1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for `tx_busy` to be 1, then go to WAIT_DONE. No timeout; the transmitter must assert busy within a bounded time.
  - WAIT_DONE: wait for `tx_busy` to be 0, then go to IDLE.
- `tx_data` holds its value from the pop until the next pop, so the transmitter may resample it at any point during the frame.
- Ordering is strictly FIFO; no byte is duplicated or skipped.

## Timing
- **Reset values:**
  - Outputs: `tx_data`=0x00, `tx_start`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0.
  - Internal: FSM in IDLE; both pointers at 0.
  - Memory contents are not reset.
- **Reset behaviour:** `reset_n` low mid-frame aborts immediately, flushing the queue and dropping any in-flight byte. The transmitter is reset by the same signal.
- **Registered status:** `full`, `empty` and `count` are registered. They update on the edge that accepts the write or pop.
- **Latency into an empty, idle queue:**
  - Write sampled at edge E0, so `empty` falls after E0.
  - Pop at E1; `tx_data` is valid and `tx_start` is high from E1 to E2.
  - Result: `tx_start` rises exactly 1 clock after `empty` falls.
- **Back-to-back bytes:** the next `tx_start` occurs 2 clocks after `tx_busy` falls (WAIT_DONE→IDLE, then IDLE→LAUNCH).
- **Busy timing:** `tx_busy` high in the same cycle as `tx_start` is tolerated; WAIT_BUSY then exits on the next edge.
- **Single pulse:** exactly one `tx_start` pulse per popped byte, never two consecutive high cycles.

## Test plan
- **Reset:** assert `reset_n`=0 mid-run → all outputs at reset values, `empty`=1, `count`=0.
- **String in order:** enqueue "H","E","L","L","O" back-to-back (0x48,0x45,0x4C,0x4C,0x4F), with a transmitter model holding busy 10 cycles →
  - five `tx_start` pulses carrying 0x48,0x45,0x4C,0x4C,0x4F in order;
  - `count` peaks at 4;
  - `empty`=1 after the last pop.
- **Overflow:** hold `tx_busy`=1 and write DEPTH+2 bytes 0x00..0x11 →
  - `full`=1 after 16 accepted writes;
  - bytes 0x10 and 0x11 dropped;
  - `overflow`=1 and stays 1 until `ovf_clr`.
- **Write/pop collision:** while full, pulse one write in the same cycle the FSM pops →
  - the write is dropped;
  - `count`=15 afterwards;
  - `overflow`=1.
- **Wrap-around:** drive 40 bytes through a DEPTH=16 queue at an interleaved rate → output sequence matches input exactly across pointer wrap.
- **Latency check:** single write into an idle, empty queue → `tx_start` high exactly 1 cycle after `empty` falls; next byte launches 2 cycles after `tx_busy` falls.
